// File: rtl/addern_operand_seq.sv
// ---------------------------------------------------------------------------
// addern_operand_seq
//
// Operand sequencer that sits in front of a combinational N-bit adder
// (Addern). The user loads operand A, then operand B together with the
// carry-in, one pushbutton press per step. The sequencer drives the stored
// operands into the adder, captures the adder's {cout,sum} one cycle later
// into a held result, and keeps showing it until the next press returns to
// operand entry. The switches may change freely between presses without
// disturbing the displayed operands or the result.
//
// Parameters
//   N        operand width, must match the Addern instance
//
// Ports
//   Clock    in   1    system clock, all state changes on the rising edge
//   Reset    in   1    synchronous, active-high reset
//   enter_n  in   1    enter pushbutton, active-low, asynchronous to Clock
//   data_in  in   N    operand value from the switches
//   cin_in   in   1    carry-in value from a switch
//   A        out  N    registered operand A to the adder
//   B        out  N    registered operand B to the adder
//   Cin      out  1    registered carry-in to the adder
//   sum_in   in   N    sum returned by the adder
//   cout_in  in   1    carry-out returned by the adder
//   result   out  N+1  held {cout_in,sum_in}, captured once per operation
//   state    out  2    current sequencer state (0=A,1=B,2=RUN,3=SHOW)
//   done     out  1    high while result holds a valid sum
// ---------------------------------------------------------------------------
module addern_operand_seq #(
  parameter int N = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         enter_n,
  input  logic [N-1:0] data_in,
  input  logic         cin_in,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic         Cin,
  input  logic [N-1:0] sum_in,
  input  logic         cout_in,
  output logic [N:0]   result,
  output logic [1:0]   state,
  output logic         done
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_RUN  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  // Button conditioning: s1/s2 form the synchroniser, s3 remembers the
  // previous synchronised level so a falling edge can be spotted.
  logic s1_q;
  logic s2_q;
  logic s3_q;

  // After reset the synchroniser still holds its forced "released" value
  // rather than a real sample of the button. If the button is already held
  // down when reset ends, the first real sample would look like a falling
  // edge. fill_q counts the edges needed for s2 to carry a genuine sample,
  // and presses are only armed once a genuine released level has been seen.
  logic [1:0] fill_q;
  logic [1:0] fill_d;
  logic       armed_q;
  logic       armed_d;
  logic       press_s;

  // Sequencer state and registered outputs.
  state_t     state_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         cin_q;
  logic [N:0]   result_q;
  logic         done_q;

  // Next-state for the arming logic: count up to two genuine samples, then
  // arm once the synchronised button reads released.
  always_comb begin
    fill_d  = fill_q;
    armed_d = armed_q;
    if (fill_q != 2'd2) begin
      fill_d = fill_q + 2'd1;
    end else begin
      fill_d = fill_q;
    end
    if ((fill_q == 2'd2) && s2_q) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Synchroniser, edge-history flop and arming state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= enter_n;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  // One-cycle pulse on each synchronised falling edge of enter_n. Holding
  // the button keeps s2 and s3 both low, so no further pulses follow.
  assign press_s = armed_q & s3_q & ~s2_q;

  // Operand/result sequencer. done is registered alongside the state so it
  // is high exactly while the state is S_SHOW.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (press_s) begin
            a_q     <= data_in;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (press_s) begin
            b_q     <= data_in;
            cin_q   <= cin_in;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // The adder has had a full cycle to settle on the new operands.
          // Any press seen here is dropped on purpose.
          result_q <= {cout_in, sum_in};
          done_q   <= 1'b1;
          state_q  <= S_SHOW;
        end
        S_SHOW: begin
          if (press_s) begin
            done_q  <= 1'b0;
            state_q <= S_A;
          end
        end
        default: begin
          state_q <= S_A;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign Cin    = cin_q;
  assign result = result_q;
  assign state  = state_q;
  assign done   = done_q;

endmodule

// File: tb/tb_addern_operand_seq.sv
module tb_addern_operand_seq;

  localparam int N = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         enter_n;
  logic [N-1:0] data_in;
  logic         cin_in;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] sum_in;
  logic         cout_in;
  logic [N:0]   result;
  logic [1:0]   state;
  logic         done;

  addern_operand_seq #(.N(N)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .enter_n (enter_n),
    .data_in (data_in),
    .cin_in  (cin_in),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .sum_in  (sum_in),
    .cout_in (cout_in),
    .result  (result),
    .state   (state),
    .done    (done)
  );

  // Behavioural Addern: plain arithmetic on the registered operands.
  assign {cout_in, sum_in} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};

  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    logic [N:0]   r;
  } exp_t;

  exp_t sbq[$];

  logic [N:0]   last_result = '0;
  logic [N-1:0] exp_a       = '0;
  int           press_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT raises done, pop the oldest expected operation.
  logic prev_done = 1'b0;
  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (dut.press_s === 1'b1) press_cnt++;
    if (done === 1'b1 && prev_done !== 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("sb_result", 32'(result), 32'(e.r));
        check("sb_A", 32'(A), 32'(e.a));
        check("sb_B", 32'(B), 32'(e.b));
        check("sb_Cin", 32'(Cin), 32'(e.c));
        check("sb_state", 32'(state), 32'd3);
      end
    end
    prev_done = done;
  end

  // One button press: drop enter_n, hold, then scramble switches and release.
  task automatic press(input logic [N-1:0] d, input logic c, input int hold);
    @(negedge Clock);
    enter_n = 1'b0;
    data_in = d;
    cin_in  = c;
    repeat (hold) @(negedge Clock);
    data_in = N'($urandom);
    cin_in  = 1'($urandom);
    enter_n = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  // Full add: A press, B/Cin press, then the press that leaves S_SHOW.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    exp_t e;
    press(a, 1'($urandom), int'($urandom_range(3, 6)));
    check("op_state_B", 32'(state), 32'd1);
    check("op_A", 32'(A), 32'(a));
    exp_a = a;
    e.a = a;
    e.b = b;
    e.c = c;
    e.r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    sbq.push_back(e);
    press(b, c, int'($urandom_range(3, 6)));
    check("op_state_show", 32'(state), 32'd3);
    check("op_done", 32'(done), 32'd1);
    last_result = e.r;
    press(N'($urandom), 1'($urandom), int'($urandom_range(3, 6)));
    check("op_exit_state", 32'(state), 32'd0);
    check("op_exit_done", 32'(done), 32'd0);
    check("op_result_held", 32'(result), 32'(last_result));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes;
    logic [1:0] prev_state;
    logic [N-1:0] d;

    // Reset with the button held down.
    Reset   = 1'b1;
    enter_n = 1'b0;
    data_in = '0;
    cin_in  = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_A", 32'(A), 32'd0);
    check("rst_B", 32'(B), 32'd0);
    check("rst_Cin", 32'(Cin), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    data_in = 4'd6;
    repeat (10) @(negedge Clock);
    check("no_press_after_rst_state", 32'(state), 32'd0);
    check("no_press_after_rst_A", 32'(A), 32'd0);
    enter_n = 1'b1;
    repeat (4) @(negedge Clock);

    // Directed adds, including overflow into the carry bit.
    do_op(4'd3, 4'd5, 1'b1);
    do_op(4'd15, 4'd15, 1'b1);
    do_op(4'd8, 4'd8, 1'b0);

    // Long press in S_A: exactly one transition and one press pulse.
    press_cnt = 0;
    changes = 0;
    @(negedge Clock);
    enter_n = 1'b0;
    data_in = 4'd12;
    prev_state = state;
    repeat (50) begin
      @(negedge Clock);
      if (state !== prev_state) changes++;
      prev_state = state;
    end
    check("long_press_state", 32'(state), 32'd1);
    check("long_press_changes", 32'(changes), 32'd1);
    check("long_press_pulses", 32'(press_cnt), 32'd1);
    check("long_press_A", 32'(A), 32'd12);
    enter_n = 1'b1;
    repeat (4) @(negedge Clock);
    check("release_no_press", 32'(press_cnt), 32'd1);
    begin
      exp_t e;
      e.a = 4'd12; e.b = 4'd2; e.c = 1'b1; e.r = 5'd15;
      sbq.push_back(e);
    end
    press(4'd2, 1'b1, 3);
    press(4'd0, 1'b0, 3);
    check("long_op_exit_state", 32'(state), 32'd0);
    exp_a = 4'd12;

    // Latency: A must only change on the third edge after enter_n falls.
    d = exp_a ^ 4'hA;
    @(negedge Clock);
    enter_n = 1'b0;
    data_in = d;
    @(posedge Clock); #1;
    check("lat_edge_k", 32'(A), 32'(exp_a));
    @(posedge Clock); #1;
    check("lat_edge_k1", 32'(A), 32'(exp_a));
    @(posedge Clock); #1;
    check("lat_edge_k2", 32'(A), 32'(d));
    @(negedge Clock);
    data_in = N'($urandom);
    enter_n = 1'b1;
    repeat (4) @(negedge Clock);
    begin
      exp_t e;
      e.a = d; e.b = 4'd9; e.c = 1'b0; e.r = {1'b0, d} + 5'd9;
      sbq.push_back(e);
    end
    press(4'd9, 1'b0, 4);
    press(4'd1, 1'b1, 4);

    // Reset mid-operation in S_B.
    press(4'd7, 1'b0, 3);
    check("mid_state_B", 32'(state), 32'd1);
    check("mid_A", 32'(A), 32'd7);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("mid_rst_A", 32'(A), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    do_op(4'd4, 4'd10, 1'b1);

    // Randomised operations.
    for (int i = 0; i < 20; i++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge Clock);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
